// File: rtl/pong_engine_if.sv
// Frame-rate control and display-coordinate bundle between the Pong game-state
// engine (slave) and whatever drives it (master).
interface pong_engine_if;
  logic       frame_tick;
  logic       btn_up;
  logic       btn_down;
  logic       btn_start;
  logic [4:0] ballX;
  logic [3:0] ballY;
  logic [3:0] playerPos;
  logic [3:0] comPos;
  logic [3:0] playerScore;
  logic [3:0] comScore;
  logic       point_strobe;
  logic       game_over;

  modport master (
    output frame_tick, btn_up, btn_down, btn_start,
    input  ballX, ballY, playerPos, comPos, playerScore, comScore,
           point_strobe, game_over
  );

  modport slave (
    input  frame_tick, btn_up, btn_down, btn_start,
    output ballX, ballY, playerPos, comPos, playerScore, comScore,
           point_strobe, game_over
  );
endinterface

// File: rtl/pong_engine.sv
// Pong game-state engine: ball physics, paddle control, computer AI and scoring,
// all advanced on frame_tick so positions only move during vertical blanking.
module pong_engine #(
  parameter int GRID_H     = 15,
  parameter int PADDLE     = 4,
  parameter int COM_COL    = 14,
  parameter int BALL_DIV   = 6,
  parameter int PAD_DIV    = 3,
  parameter int SERVE_WAIT = 60,
  parameter int WIN_SCORE  = 9
) (
  input  logic          CLK_IN,
  input  logic          RESET,
  pong_engine_if.slave  bus
);

  localparam int SC_W = $clog2(SERVE_WAIT);
  localparam int BD_W = $clog2(BALL_DIV);
  localparam int PD_W = $clog2(PAD_DIV);

  localparam logic [3:0]      MAX_POS   = 4'(GRID_H - 1 - PADDLE);
  localparam logic [3:0]      Y_MAX     = 4'(GRID_H - 1);
  localparam logic [4:0]      X_RIGHT   = 5'(COM_COL - 1);
  localparam logic [4:0]      X_START   = 5'd7;
  localparam logic [3:0]      Y_START   = 4'd7;
  localparam logic [3:0]      POS_START = 4'd5;
  localparam logic [SC_W-1:0] SC_LAST   = SC_W'(SERVE_WAIT - 1);
  localparam logic [BD_W-1:0] BD_LAST   = BD_W'(BALL_DIV - 1);
  localparam logic [PD_W-1:0] PD_LAST   = PD_W'(PAD_DIV - 1);

  typedef enum logic [1:0] {S_SERVE, S_PLAY, S_SCORE, S_OVER} state_t;

  state_t          state_q, state_d;
  logic [4:0]      ballX_q, ballX_d;
  logic [3:0]      ballY_q, ballY_d;
  logic [3:0]      ppos_q, ppos_d;
  logic [3:0]      cpos_q, cpos_d;
  logic [3:0]      pscore_q, pscore_d;
  logic [3:0]      cscore_q, cscore_d;
  logic            dx_q, dx_d;        // 1: moving right (+1), 0: moving left
  logic            dy_q, dy_d;        // 1: moving down (+1), 0: moving up
  logic            point_q, point_d;
  logic            pwin_q, pwin_d;    // last miss was the computer's
  logic [SC_W-1:0] serve_cnt_q, serve_cnt_d;
  logic [BD_W-1:0] ball_div_q, ball_div_d;
  logic [PD_W-1:0] pad_div_q, pad_div_d;

  logic       running, pad_step, serve_go, ball_step;
  logic       dy_n, at_left, at_right, p_hit, c_hit, miss, win;
  logic [3:0] ny, new_score;
  logic [4:0] com_mid;

  function automatic logic [3:0] step_pos(input logic [3:0] pos, input logic inc,
                                          input logic dec);
    logic [3:0] r;
    r = pos;
    if (inc && !dec && pos != MAX_POS) r = pos + 4'd1;
    else if (dec && !inc && pos != 4'd0) r = pos - 4'd1;
    return r;
  endfunction

  assign running   = (state_q == S_SERVE) || (state_q == S_PLAY);
  assign pad_step  = bus.frame_tick && running && (pad_div_q == PD_LAST);
  assign serve_go  = bus.frame_tick && (state_q == S_SERVE) && (serve_cnt_q == SC_LAST);
  assign ball_step = bus.frame_tick && (state_q == S_PLAY) && (ball_div_q == BD_LAST);

  // Wall reflection is resolved before the move so ny never leaves 0..GRID_H-1.
  assign dy_n      = dy_q ^ (((ballY_q == 4'd0) && !dy_q) || ((ballY_q == Y_MAX) && dy_q));
  assign ny        = dy_n ? ballY_q + 4'd1 : ballY_q - 4'd1;
  assign at_left   = !dx_q && (ballX_q == 5'd1);
  assign at_right  = dx_q && (ballX_q == X_RIGHT);
  assign p_hit     = (ny >= ppos_q) && ({1'b0, ny} <= {1'b0, ppos_q} + 5'(PADDLE));
  assign c_hit     = (ny >= cpos_q) && ({1'b0, ny} <= {1'b0, cpos_q} + 5'(PADDLE));
  assign miss      = ball_step && ((at_left && !p_hit) || (at_right && !c_hit));
  assign new_score = (pwin_q ? pscore_q : cscore_q) + 4'd1;
  assign win       = (new_score == 4'(WIN_SCORE));
  assign com_mid   = {1'b0, cpos_q} + 5'd2;

  always_ff @(posedge CLK_IN or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_SERVE;
      ballX_q     <= X_START;
      ballY_q     <= Y_START;
      ppos_q      <= POS_START;
      cpos_q      <= POS_START;
      pscore_q    <= '0;
      cscore_q    <= '0;
      dx_q        <= 1'b1;
      dy_q        <= 1'b1;
      point_q     <= 1'b0;
      pwin_q      <= 1'b0;
      serve_cnt_q <= '0;
      ball_div_q  <= '0;
      pad_div_q   <= '0;
    end else begin
      state_q     <= state_d;
      ballX_q     <= ballX_d;
      ballY_q     <= ballY_d;
      ppos_q      <= ppos_d;
      cpos_q      <= cpos_d;
      pscore_q    <= pscore_d;
      cscore_q    <= cscore_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      point_q     <= point_d;
      pwin_q      <= pwin_d;
      serve_cnt_q <= serve_cnt_d;
      ball_div_q  <= ball_div_d;
      pad_div_q   <= pad_div_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SERVE: if (serve_go) state_d = S_PLAY;
      S_PLAY:  if (miss) state_d = S_SCORE;
      S_SCORE: state_d = win ? S_OVER : S_SERVE;
      S_OVER:  if (bus.btn_start) state_d = S_SERVE;
      default: state_d = S_SERVE;
    endcase
  end

  always_comb begin
    ballX_d     = ballX_q;
    ballY_d     = ballY_q;
    ppos_d      = ppos_q;
    cpos_d      = cpos_q;
    pscore_d    = pscore_q;
    cscore_d    = cscore_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    point_d     = 1'b0;
    pwin_d      = pwin_q;
    serve_cnt_d = serve_cnt_q;
    ball_div_d  = ball_div_q;
    pad_div_d   = pad_div_q;

    if (bus.frame_tick && running) pad_div_d = pad_step ? '0 : pad_div_q + PD_W'(1);
    // Paddles and hit test both read the pre-edge positions.
    if (pad_step) begin
      ppos_d = step_pos(ppos_q, bus.btn_down, bus.btn_up);
      cpos_d = step_pos(cpos_q, com_mid < {1'b0, ballY_q}, com_mid > {1'b0, ballY_q});
    end

    case (state_q)
      S_SERVE: if (bus.frame_tick) begin
        serve_cnt_d = serve_go ? '0 : serve_cnt_q + SC_W'(1);
        if (serve_go) begin
          ballX_d    = X_START;
          ballY_d    = Y_START;
          dy_d       = 1'b1;
          ball_div_d = '0;
        end
      end
      S_PLAY: if (bus.frame_tick) begin
        ball_div_d = ball_step ? '0 : ball_div_q + BD_W'(1);
        if (ball_step) begin
          dy_d    = dy_n;
          ballY_d = ny;
          if (at_left) begin
            if (p_hit) begin dx_d = 1'b1; ballX_d = 5'd2; end
            else begin ballX_d = 5'd0; pwin_d = 1'b0; end
          end else if (at_right) begin
            if (c_hit) begin dx_d = 1'b0; ballX_d = 5'(COM_COL - 2); end
            else begin ballX_d = 5'(COM_COL); pwin_d = 1'b1; end
          end else begin
            ballX_d = dx_q ? ballX_q + 5'd1 : ballX_q - 5'd1;
          end
        end
      end
      S_SCORE: begin
        point_d     = 1'b1;
        dx_d        = pwin_q;
        serve_cnt_d = '0;
        if (pwin_q) pscore_d = new_score;
        else        cscore_d = new_score;
      end
      S_OVER: if (bus.btn_start) begin
        pscore_d    = '0;
        cscore_d    = '0;
        dx_d        = 1'b1;
        serve_cnt_d = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.ballX        = ballX_q;
    bus.ballY        = ballY_q;
    bus.playerPos    = ppos_q;
    bus.comPos       = cpos_q;
    bus.playerScore  = pscore_q;
    bus.comScore     = cscore_q;
    bus.point_strobe = point_q;
    bus.game_over    = (state_q == S_OVER);
  end

endmodule

// File: tb/tb_pong_engine.sv
// Bench for pong_engine: hand-computed vector table from reset, then random play
// against a frame-level game model, game-over/restart and mid-play reset sequences.
module tb_pong_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pong_engine_if bus();

  pong_engine dut (
    .CLK_IN (clk),
    .RESET  (rst),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  // Game model: mode 0 serve, 1 play, 2 point pending, 3 over.
  int m_mode, m_bx, m_by, m_dx, m_dy, m_pp, m_cp, m_ps, m_cs, m_strobe;
  int m_serve_frames, m_play_frames, m_pad_frames;
  bit m_player_scored;

  typedef struct {
    int ticks;
    bit up;
    bit down;
    int bx;
    int by;
    int pp;
    int cp;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_bx = 7; m_by = 7; m_dx = 1; m_dy = 1; m_pp = 5; m_cp = 5;
    m_ps = 0; m_cs = 0; m_strobe = 0;
    m_serve_frames = 0; m_play_frames = 0; m_pad_frames = 0;
    m_player_scored = 0;
  endtask

  task automatic model_frame(input bit up, input bit down);
    int pp0, cp0, by0, ny;
    m_strobe = 0;
    if (m_mode == 0 || m_mode == 1) begin
      pp0 = m_pp; cp0 = m_cp; by0 = m_by;
      m_pad_frames++;
      if (m_pad_frames % 3 == 0) begin
        if (up && !down)      m_pp = (m_pp > 0)  ? m_pp - 1 : 0;
        else if (down && !up) m_pp = (m_pp < 10) ? m_pp + 1 : 10;
        if (cp0 + 2 < by0)      m_cp = (cp0 < 10) ? cp0 + 1 : 10;
        else if (cp0 + 2 > by0) m_cp = (cp0 > 0)  ? cp0 - 1 : 0;
      end
      if (m_mode == 0) begin
        m_serve_frames++;
        if (m_serve_frames == 60) begin
          m_mode = 1; m_bx = 7; m_by = 7; m_dy = 1;
          m_play_frames = 0; m_serve_frames = 0;
        end
      end else begin
        m_play_frames++;
        if (m_play_frames % 6 == 0) begin
          if ((m_by == 0 && m_dy < 0) || (m_by == 14 && m_dy > 0)) m_dy = -m_dy;
          ny = m_by + m_dy;
          if (m_dx < 0 && m_bx == 1) begin
            if (ny >= pp0 && ny <= pp0 + 4) begin m_dx = 1; m_bx = 2; end
            else begin m_bx = 0; m_mode = 2; m_player_scored = 0; end
          end else if (m_dx > 0 && m_bx == 13) begin
            if (ny >= cp0 && ny <= cp0 + 4) begin m_dx = -1; m_bx = 12; end
            else begin m_bx = 14; m_mode = 2; m_player_scored = 1; end
          end else begin
            m_bx = m_bx + m_dx;
          end
          m_by = ny;
        end
      end
    end
  endtask

  task automatic model_score_clock();
    m_strobe = 0;
    if (m_mode == 2) begin
      m_strobe = 1;
      if (m_player_scored) begin m_ps++; m_dx = 1; end
      else begin m_cs++; m_dx = -1; end
      m_mode = (m_ps == 9 || m_cs == 9) ? 3 : 0;
      m_serve_frames = 0;
    end
  endtask

  task automatic model_start();
    m_strobe = 0;
    if (m_mode == 3) begin
      m_ps = 0; m_cs = 0; m_dx = 1; m_mode = 0; m_serve_frames = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".ballX"},        int'(bus.ballX),        m_bx);
    chk({tag, ".ballY"},        int'(bus.ballY),        m_by);
    chk({tag, ".playerPos"},    int'(bus.playerPos),    m_pp);
    chk({tag, ".comPos"},       int'(bus.comPos),       m_cp);
    chk({tag, ".playerScore"},  int'(bus.playerScore),  m_ps);
    chk({tag, ".comScore"},     int'(bus.comScore),     m_cs);
    chk({tag, ".point_strobe"}, int'(bus.point_strobe), m_strobe);
    chk({tag, ".game_over"},    int'(bus.game_over),    (m_mode == 3) ? 1 : 0);
  endtask

  // One frame = tick clock, then a quiet clock in which a pending point lands.
  task automatic frame(input bit up, input bit down);
    @(negedge clk);
    bus.frame_tick = 1'b1; bus.btn_up = up; bus.btn_down = down;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    model_frame(up, down);
    compare_all("frame");
    @(negedge clk);
    model_score_clock();
    compare_all("gap");
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.btn_start = 1'b1;
    @(negedge clk);
    bus.btn_start = 1'b0;
    model_start();
    compare_all("start");
  endtask

  task automatic rand_frame();
    logic [1:0] r;
    r = 2'($urandom_range(0, 3));
    frame(r[0], r[1]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sx, sy, spp, scp;
    bus.frame_tick = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_start = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.ballX", int'(bus.ballX), 7);
    chk("rst.ballY", int'(bus.ballY), 7);
    chk("rst.playerPos", int'(bus.playerPos), 5);
    chk("rst.comPos", int'(bus.comPos), 5);
    chk("rst.scores", int'(bus.playerScore) + int'(bus.comScore), 0);
    chk("rst.point_strobe", int'(bus.point_strobe), 0);
    chk("rst.game_over", int'(bus.game_over), 0);
    rst = 1'b0;
    model_reset();

    // Cumulative frames from reset; expected values worked out by hand.
    vecs[0] = '{0,  0, 0, 7, 7, 5, 5};
    vecs[1] = '{3,  1, 0, 7, 7, 4, 5};
    vecs[2] = '{3,  0, 1, 7, 7, 5, 5};
    vecs[3] = '{3,  1, 1, 7, 7, 5, 5};
    vecs[4] = '{3,  1, 0, 7, 7, 4, 5};
    vecs[5] = '{48, 0, 0, 7, 7, 4, 5};
    vecs[6] = '{6,  0, 0, 8, 8, 4, 5};
    vecs[7] = '{3,  0, 0, 8, 8, 4, 6};
    vecs[8] = '{3,  0, 0, 9, 9, 4, 6};
    for (int i = 0; i < 9; i++) begin
      for (int k = 0; k < vecs[i].ticks; k++) frame(vecs[i].up, vecs[i].down);
      chk($sformatf("vec%0d.ballX", i),     int'(bus.ballX),     vecs[i].bx);
      chk($sformatf("vec%0d.ballY", i),     int'(bus.ballY),     vecs[i].by);
      chk($sformatf("vec%0d.playerPos", i), int'(bus.playerPos), vecs[i].pp);
      chk($sformatf("vec%0d.comPos", i),    int'(bus.comPos),    vecs[i].cp);
    end

    // Random play until someone wins; stray btn_start pulses must be ignored.
    for (int f = 0; f < 12000; f++) begin
      if (m_mode == 3) break;
      rand_frame();
      if ($urandom_range(0, 49) == 0 && m_mode != 3) pulse_start();
    end
    chk("reach_over", int'(bus.game_over), 1);
    chk("win_score", (bus.playerScore == 4'd9 || bus.comScore == 4'd9) ? 1 : 0, 1);

    sx = m_bx; sy = m_by; spp = m_pp; scp = m_cp;
    for (int f = 0; f < 9; f++) frame(1'b0, 1'b1);
    chk("over.ballX", int'(bus.ballX), sx);
    chk("over.ballY", int'(bus.ballY), sy);
    chk("over.playerPos", int'(bus.playerPos), spp);
    chk("over.comPos", int'(bus.comPos), scp);

    pulse_start();
    chk("restart.scores", int'(bus.playerScore) + int'(bus.comScore), 0);
    chk("restart.game_over", int'(bus.game_over), 0);

    spp = m_pp;
    for (int f = 0; f < 6; f++) frame(1'b1, 1'b1);
    chk("both_btns.playerPos", int'(bus.playerPos), spp);
    for (int f = 0; f < 36; f++) frame(1'b1, 1'b0);
    chk("up_top.playerPos", int'(bus.playerPos), 0);
    for (int f = 0; f < 6; f++) frame(1'b1, 1'b0);
    chk("up_sat.playerPos", int'(bus.playerPos), 0);
    for (int f = 0; f < 36; f++) frame(1'b0, 1'b1);
    chk("down_sat.playerPos", int'(bus.playerPos), 10);

    for (int f = 0; f < 100; f++) begin
      if (m_mode == 1) break;
      rand_frame();
    end
    for (int f = 0; f < 8; f++) rand_frame();

    // Asynchronous reset mid-clock with a coincident, ignored frame_tick.
    @(negedge clk);
    bus.frame_tick = 1'b1;
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("arst.ballX", int'(bus.ballX), 7);
    chk("arst.ballY", int'(bus.ballY), 7);
    chk("arst.playerPos", int'(bus.playerPos), 5);
    chk("arst.comPos", int'(bus.comPos), 5);
    chk("arst.scores", int'(bus.playerScore) + int'(bus.comScore), 0);
    chk("arst.game_over", int'(bus.game_over), 0);
    @(negedge clk);
    bus.frame_tick = 1'b0;
    rst = 1'b0;
    compare_all("post_rst");

    for (int f = 0; f < 66; f++) frame(1'b0, 1'b0);
    chk("relaunch.ballX", int'(bus.ballX), 8);
    chk("relaunch.ballY", int'(bus.ballY), 8);

    for (int f = 0; f < 600; f++) rand_frame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pong_engine.md
# pong_engine

Game-state engine for the VGA Pong design on a 20×15 grid of 32×32-pixel cells. It advances ball physics, player paddle control, the computer-paddle AI and scoring once per video frame. It drives the ball/paddle cell coordinates consumed by the pixel-colour builder. All updates are gated by a one-clock frame pulse, so positions never change during active video.

## Interface
- GRID_H, 15: grid rows; valid Y is 0..14.
- PADDLE, 4: paddle extent; a paddle at `pos` covers rows pos..pos+PADDLE. Maximum `pos` is GRID_H-1-PADDLE = 10.
- COM_COL, 14: computer paddle column. The player paddle column is fixed at 0.
- BALL_DIV, 6: frames per ball step in PLAY.
- PAD_DIV, 3: frames per paddle step.
- SERVE_WAIT, 60: frames held in SERVE before launch.
- WIN_SCORE, 9: score that ends the game.
- CLK_IN  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-clock pulse per frame (start of vertical blanking).
- btn_up, btn_down  in  1 each  player paddle controls, already synchronised and debounced; "up" means decreasing Y.
- btn_start  in  1  restarts the game from OVER.
- ballX  out  5  ball column, registered.
- ballY  out  4  ball row, registered.
- playerPos, comPos  out  4 each  top row of each paddle, registered.
- playerScore, comScore  out  4 each  scores, registered.
- point_strobe  out  1  one-clock pulse when a point is awarded.
- game_over  out  1  high while in OVER.

## Operation
- Reset values: ballX=7, ballY=7, playerPos=5, comPos=5, both scores 0, point_strobe=0, game_over=0. State SERVE, serve counter 0, dx=+1, dy=+1, both dividers 0.
- States:
  - SERVE: counts frame_ticks. On the SERVE_WAIT-th tick: ball loads (7,7), dy loads +1, ball divider clears, state goes to PLAY.
  - PLAY: normal play, described below.
  - SCORE: lasts exactly one clock. Increments the scorer's score, pulses point_strobe, then goes to OVER if the new score equals WIN_SCORE, else SERVE. Serve dx points at the conceding side: -1 if the computer scored, +1 if the player scored.
  - OVER: all positions frozen, game_over=1. btn_start clears both scores and goes to SERVE with dx=+1.
- Paddle divider (runs in SERVE and PLAY, frozen in OVER): on each PAD_DIV-th frame_tick, take one paddle step.
  - Player: btn_up alone decrements playerPos (saturates at 0). btn_down alone increments it (saturates at 10). Both or neither: no move.
  - Computer: if comPos+2 < ballY, increment (saturates at 10). If comPos+2 > ballY, decrement (saturates at 0). Otherwise hold.
- Ball step (PLAY, on each BALL_DIV-th frame_tick):
  - Vertical: if (ballY==0 and dy=-1) or (ballY==GRID_H-1 and dy=+1), negate dy first. Then ny = ballY+dy.
  - Left edge: if dx=-1 and ballX==1:
    - Hit when playerPos ≤ ny ≤ playerPos+PADDLE: dx becomes +1, ballX becomes 2.
    - Miss otherwise: ballX becomes 0 and state goes to SCORE (computer scores).
  - Right edge, mirrored: if dx=+1 and ballX==COM_COL-1:
    - Hit against comPos: dx becomes -1, ballX becomes COM_COL-2.
    - Miss: ballX becomes COM_COL and state goes to SCORE (player scores).
  - Otherwise: ballX = ballX+dx.
  - ballY = ny in all cases.
- After a miss, the ball stays at the miss column through the whole SERVE wait.
- Arithmetic: positions are unsigned. Edge checks precede every add or subtract, so no value wraps. Scores are 4-bit and cannot exceed WIN_SCORE.

## Timing
- All outputs change on the CLK_IN edge following the frame_tick-qualified event, a latency of 1 clock. They are stable for the rest of the frame.
- Simultaneous paddle step and ball step on the same tick: the hit test uses the paddle positions registered before that edge.
- RESET asserted mid-game: all registers return to reset values asynchronously. A frame_tick coinciding with RESET is ignored.
- btn_start is ignored outside OVER. Buttons are sampled only on paddle-step ticks.
- frame_tick during SCORE is not counted by any divider.

## Test plan
- Reset: assert RESET mid-PLAY → next cycle ballX=7, ballY=7, playerPos=5, comPos=5, scores 0, game_over=0.
- Serve and first move: 60 frame_ticks → PLAY. 6 further ticks → ball at (8,8).
- Wall bounce: ball at (5,14) with dy=+1 and dx=+1 → next step ball at (6,13) with dy=-1. At (5,0) with dy=-1 → next step (6,1).
- Player hit: playerPos=5, ball at (1,6) moving left with dy=+1 → next step (2,7), dx=+1. Check ny=9 is a hit and ny=10 is a miss.
- Player miss: playerPos=0, ball at (1,12) moving left → ballX=0, then one clock later comScore 0→1 with a single point_strobe. After the SERVE wait, the ball restarts at (7,7) with dx=-1.
- Game end and controls: computer reaches 9 → game_over=1 and positions frozen under frame_ticks. btn_start → scores 0, SERVE. With btn_up and btn_down both held, playerPos is unchanged; with btn_up held at playerPos=0, it stays 0.
